dmem_arbiter: RTL and testbench

- Shares the single-port data_mem between two requesters: the core load/store path (requester 0) and a host loader/debug port (requester 1), which fills or dumps memory around a run.
- Each requester uses a req/ack handshake; the arbiter registers the winner's command, drives data_mem for exactly one cycle, then returns an ack with read data.
- Core has fixed priority; a starvation counter forces a host grant after STARVE_MAX consecutive core wins while the host is waiting.

---
 rtl/dmem_arbiter_if.sv | 44 ++++
 rtl/dmem_arbiter.sv | 108 ++++++++++
 tb/tb_dmem_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data_mem requesters (core, host), the arbiter and data_mem itself.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dmem_arbiter_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_ack;

    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;

    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          owner;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  host_req, host_we, host_addr, host_wdata,
        input  mem_rdata,
        output core_ack, host_ack, rdata,
        output mem_addr, mem_we, mem_wdata,
        output busy, owner
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output host_req, host_we, host_addr, host_wdata,
        output mem_rdata,
        input  core_ack, host_ack, rdata,
        input  mem_addr, mem_we, mem_wdata,
        input  busy, owner
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data_mem: core has fixed priority, host is forced
// through after STARVE_MAX consecutive core wins. Each access is IDLE -> ACCESS -> RESP.
module dmem_arbiter #(
    parameter int unsigned AW         = 8,
    parameter int unsigned DW         = 8,
    parameter int unsigned STARVE_MAX = 3
) (
    input logic            CLK,
    input logic            reset_n,
    dmem_arbiter_if.slave  bus
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StResp   = 2'd2;

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    logic [1:0]    state_q, state_d;
    logic          we_q, we_d;
    logic          owner_q, owner_d;
    logic [3:0]    starve_q, starve_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          host_win;

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        host_win = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.core_req || bus.host_req) begin
                    host_win = bus.host_req && ((starve_q == StarveMax) || !bus.core_req);
                    if (host_win) begin
                        we_d     = bus.host_we;
                        addr_d   = bus.host_addr;
                        wdata_d  = bus.host_wdata;
                        owner_d  = 1'b1;
                        starve_d = 4'd0;
                    end else begin
                        we_d    = bus.core_we;
                        addr_d  = bus.core_addr;
                        wdata_d = bus.core_wdata;
                        owner_d = 1'b0;
                        // Only core wins that keep a waiting host out count toward starvation.
                        if (!bus.host_req) begin
                            starve_d = 4'd0;
                        end else if (starve_q != StarveMax) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (!we_q) begin
                    rdata_d = bus.mem_rdata;
                end
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            owner_q  <= 1'b0;
            starve_q <= 4'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    // Decoded from state so that an asynchronous reset drops the write strobe at once.
    assign bus.mem_we    = (state_q == StAccess) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.core_ack  = (state_q == StResp) && !owner_q;
    assign bus.host_ack  = (state_q == StResp) && owner_q;
    assign bus.busy      = (state_q == StAccess) || (state_q == StResp);
    assign bus.owner     = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected grants are queued as requests are driven and
// checked against every ack and every write strobe seen on the memory side.
module tb_dmem_arbiter;

    typedef struct packed {
        logic       id;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } exp_t;

    logic CLK;
    logic reset_n;

    dmem_arbiter_if #(.AW(8), .DW(8)) bus ();

    dmem_arbiter #(
        .AW        (8),
        .DW        (8),
        .STARVE_MAX(3)
    ) u_dut (
        .CLK    (CLK),
        .reset_n(reset_n),
        .bus    (bus)
    );

    logic [7:0] mem     [256];
    logic [7:0] exp_mem [256];
    exp_t       sb_q    [$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int mem_we_cycles = 0;
    int core_acks = 0;
    int host_acks = 0;
    int last_core_cyc = 0;
    int last_host_cyc = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = mem[bus.mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (reset_n) begin
            if (bus.mem_we) begin
                mem_we_cycles++;
                check("we_has_entry", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    check("mem_we_kind", bus.mem_we, sb_q[0].we);
                    check("mem_addr", bus.mem_addr, sb_q[0].addr);
                    check("mem_wdata", bus.mem_wdata, sb_q[0].wdata);
                end
            end
            if (bus.core_ack || bus.host_ack) begin
                check("ack_overlap", bus.core_ack & bus.host_ack, 0);
                check("ack_has_entry", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("ack_id", bus.host_ack, e.id);
                    if (!e.we) check("rdata", bus.rdata, e.rdata);
                end
                if (bus.host_ack) begin
                    host_acks++;
                    last_host_cyc = cyc;
                end else begin
                    core_acks++;
                    last_core_cyc = cyc;
                end
            end
        end
    end

    function automatic exp_t mk_exp(input logic id, input logic we, input logic [7:0] addr,
                                    input logic [7:0] wdata);
        exp_t e;
        e.id    = id;
        e.we    = we;
        e.addr  = addr;
        e.wdata = we ? wdata : 8'h00;
        e.rdata = we ? 8'h00 : exp_mem[addr];
        if (we) exp_mem[addr] = wdata;
        return e;
    endfunction

    task automatic drive_req(input logic id, input logic req, input logic we,
                             input logic [7:0] addr, input logic [7:0] wdata);
        if (id) begin
            bus.host_req = req; bus.host_we = we; bus.host_addr = addr; bus.host_wdata = wdata;
        end else begin
            bus.core_req = req; bus.core_we = we; bus.core_addr = addr; bus.core_wdata = wdata;
        end
    endtask

    // Full handshake for one requester; lat counts negedges from request to ack.
    task automatic do_access(input logic id, input logic we, input logic [7:0] addr,
                             input logic [7:0] wdata, output int lat);
        sb_q.push_back(mk_exp(id, we, addr, wdata));
        drive_req(id, 1'b1, we, addr, wdata);
        for (lat = 1; lat <= 20; lat++) begin
            @(negedge CLK);
            if (id ? bus.host_ack : bus.core_ack) break;
        end
        check(id ? "host_ack_seen" : "core_ack_seen", 32'(lat <= 20), 1);
        @(posedge CLK);
        #1;
        drive_req(id, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, lat_h, lat_c, w0, h0, c0, n;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'h00;
            exp_mem[i] = 8'h00;
        end
        reset_n = 1'b0;
        drive_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy", bus.busy, 0);
        check("rst_owner", bus.owner, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_acks", {bus.core_ack, bus.host_ack}, 0);
        @(posedge CLK);
        #1;
        reset_n = 1'b1;

        // Host write 0x10 <= 0xA5, cycle by cycle.
        w0 = mem_we_cycles;
        sb_q.push_back(mk_exp(1'b1, 1'b1, 8'h10, 8'hA5));
        drive_req(1'b1, 1'b1, 1'b1, 8'h10, 8'hA5);
        @(negedge CLK);
        check("t1_idle_busy", bus.busy, 0);
        @(negedge CLK);
        check("t1_acc_mem_we", bus.mem_we, 1);
        check("t1_acc_addr", bus.mem_addr, 8'h10);
        check("t1_acc_ack", bus.host_ack, 0);
        @(negedge CLK);
        check("t1_resp_ack", bus.host_ack, 1);
        check("t1_resp_mem_we", bus.mem_we, 0);
        check("t1_owner", bus.owner, 1);
        @(posedge CLK);
        #1;
        drive_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge CLK);
        check("t1_after_busy", bus.busy, 0);
        check("t1_we_cycles", 32'(mem_we_cycles - w0), 1);
        check("t1_mem10", mem[8'h10], 8'hA5);

        // Core read of 0x10.
        w0 = mem_we_cycles;
        @(posedge CLK);
        #1;
        do_access(1'b0, 1'b0, 8'h10, 8'h00, lat);
        check("t2_latency", lat, 3);
        check("t2_no_write", 32'(mem_we_cycles - w0), 0);
        check("t2_owner", bus.owner, 0);
        check("t2_rdata_held", bus.rdata, 8'hA5);

        // Host alone, core arrives during the host's ACCESS.
        fork
            do_access(1'b1, 1'b1, 8'h30, 8'h5C, lat_h);
            begin
                @(posedge CLK);
                #1;
                do_access(1'b0, 1'b0, 8'h30, 8'h00, lat_c);
            end
        join
        check("t4_host_latency", lat_h, 3);
        check("t4_core_after_host", last_core_cyc - last_host_cyc, 3);

        // Both requesters hold req: C,C,C,H,C,C,C,H.
        h0 = host_acks;
        c0 = core_acks;
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 3) sb_q.push_back(mk_exp(1'b1, 1'b0, 8'h30, 8'h00));
            else            sb_q.push_back(mk_exp(1'b0, 1'b0, 8'h10, 8'h00));
        end
        drive_req(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
        drive_req(1'b1, 1'b1, 1'b0, 8'h30, 8'h00);
        for (n = 0; n < 60; n++) begin
            @(negedge CLK);
            #1;
            if (sb_q.size() == 0) break;
        end
        check("t3_all_served", sb_q.size(), 0);
        @(posedge CLK);
        #1;
        drive_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        check("t3_host_acks", host_acks - h0, 2);
        check("t3_core_acks", core_acks - c0, 6);

        // Reset pulsed during the ACCESS of a core write to 0x20.
        @(posedge CLK);
        #1;
        sb_q.push_back(mk_exp(1'b0, 1'b1, 8'h20, 8'h77));
        drive_req(1'b0, 1'b1, 1'b1, 8'h20, 8'h77);
        @(posedge CLK);
        #2;
        check("t5_we_before_rst", bus.mem_we, 1);
        reset_n = 1'b0;
        #1;
        check("t5_we_async_drop", bus.mem_we, 0);
        check("t5_no_ack", {bus.core_ack, bus.host_ack}, 0);
        #1;
        reset_n = 1'b1;
        for (n = 1; n <= 20; n++) begin
            @(negedge CLK);
            if (n == 1) check("t5_mem20_kept", mem[8'h20], 8'h00);
            if (bus.core_ack) break;
        end
        check("t5_retry_latency", n, 3);
        @(posedge CLK);
        #1;
        drive_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        check("t5_mem20_written", mem[8'h20], 8'h77);

        // Drop req right after ack: one ack only, idle afterwards.
        h0 = host_acks;
        do_access(1'b1, 1'b0, 8'h20, 8'h00, lat);
        @(negedge CLK);
        check("t6_busy_low", bus.busy, 0);
        repeat (4) @(negedge CLK);
        check("t6_single_ack", host_acks - h0, 1);
        check("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
